// File: rtl/riscv_ex_mc_pkg.sv
// Shared encodings for the riscv_ex_mc execute stage: RV32I/RV64I funct3 values,
// M-extension funct3 values and the controller state type.
package riscv_ex_mc_pkg;

    localparam logic [2:0] FUNCT3_ADD  = 3'b000;
    localparam logic [2:0] FUNCT3_SLL  = 3'b001;
    localparam logic [2:0] FUNCT3_SLT  = 3'b010;
    localparam logic [2:0] FUNCT3_SLTU = 3'b011;
    localparam logic [2:0] FUNCT3_XOR  = 3'b100;
    localparam logic [2:0] FUNCT3_SR   = 3'b101;
    localparam logic [2:0] FUNCT3_OR   = 3'b110;
    localparam logic [2:0] FUNCT3_AND  = 3'b111;

    localparam logic [2:0] FUNCT3_MUL    = 3'b000;
    localparam logic [2:0] FUNCT3_MULH   = 3'b001;
    localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
    localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
    localparam logic [2:0] FUNCT3_DIV    = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
    localparam logic [2:0] FUNCT3_REM    = 3'b110;
    localparam logic [2:0] FUNCT3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/riscv_ex_mc_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, XLEN steps.
// Operands must be magnitudes; sign handling lives in the execute stage.
module riscv_divider #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o,
    output logic            done_o
);
    localparam int CW = $clog2(XLEN);

    logic [XLEN-1:0] quo_q, rem_q, dvs_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q;
    logic [XLEN:0]   shifted, diff;

    // diff MSB set means the trial subtraction went negative (restore)
    assign shifted = {rem_q, quo_q[XLEN-1]};
    assign diff    = shifted - {1'b0, dvs_q};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (abort_i) begin
            busy_q <= 1'b0;
        end else if (start_i) begin
            quo_q  <= dividend_i;
            rem_q  <= '0;
            dvs_q  <= divisor_i;
            cnt_q  <= CW'(XLEN - 1);
            busy_q <= 1'b1;
        end else if (busy_q) begin
            if (!diff[XLEN]) begin
                rem_q <= diff[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b1};
            end else begin
                rem_q <= shifted[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b0};
            end
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0) busy_q <= 1'b0;
        end
    end

    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;
    assign done_o      = busy_q && (cnt_q == '0);

endmodule

// File: rtl/riscv_ex_mc.sv
// Execute stage: single-cycle ALU/multiplier, iterative divider, valid/ready on
// both sides with flush. Divide-by-zero and signed overflow bypass the divider.
module riscv_ex_mc
    import riscv_ex_mc_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int REGN = 32,
    parameter int REGA = $clog2(REGN),
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [REGA-1:0] rdi_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [2:0]      funct3_i,
    input  logic            alt_i,
    input  logic            muldiv_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic [REGA-1:0] rd_o
);
    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [REGA-1:0]   rd_q, rd_d, rd_lat_q, rd_lat_d;
    logic              neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d, rem_sel_q, rem_sel_d;

    logic              accept, is_div, div_signed, sa, sb, b_zero, div_ovf, mul_sa, mul_sb;
    logic              div_start, div_done;
    logic [XLEN-1:0]   a_abs, b_abs, alu_res, mul_res, corner_res, ex_res;
    logic [XLEN-1:0]   div_quo, div_rem, quo_fix, rem_fix, div_res;
    logic [2*XLEN-1:0] mul_a, mul_b, prod;

    assign in_ready_o = (state_q == ST_IDLE) && (!out_valid_q || out_ready_i) && !flush_i && !rst_i;
    assign accept     = in_valid_i && in_ready_o;

    assign is_div     = muldiv_i & funct3_i[2];
    assign div_signed = ~funct3_i[0];
    assign sa         = div_signed & a_i[XLEN-1];
    assign sb         = div_signed & b_i[XLEN-1];
    assign a_abs      = sa ? -a_i : a_i;
    assign b_abs      = sb ? -b_i : b_i;
    assign b_zero     = (b_i == '0);
    assign div_ovf    = div_signed && (a_i == MIN) && (b_i == '1);
    assign corner_res = b_zero ? (funct3_i[1] ? a_i : '1) : (funct3_i[1] ? '0 : MIN);

    // Sign-extend to 2*XLEN so one unsigned multiply covers all four variants
    assign mul_sa  = (funct3_i == FUNCT3_MULH) || (funct3_i == FUNCT3_MULHSU);
    assign mul_sb  = (funct3_i == FUNCT3_MULH);
    assign mul_a   = {{XLEN{mul_sa & a_i[XLEN-1]}}, a_i};
    assign mul_b   = {{XLEN{mul_sb & b_i[XLEN-1]}}, b_i};
    assign prod    = mul_a * mul_b;
    assign mul_res = (funct3_i == FUNCT3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    always_comb begin
        alu_res = '0;
        case (funct3_i)
            FUNCT3_ADD:  alu_res = alt_i ? (a_i - b_i) : (a_i + b_i);
            FUNCT3_SLL:  alu_res = a_i << b_i[SHW-1:0];
            FUNCT3_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
            FUNCT3_SLTU: alu_res = {{(XLEN-1){1'b0}}, a_i < b_i};
            FUNCT3_XOR:  alu_res = a_i ^ b_i;
            FUNCT3_SR:   alu_res = alt_i ? XLEN'($signed(a_i) >>> b_i[SHW-1:0]) : (a_i >> b_i[SHW-1:0]);
            FUNCT3_OR:   alu_res = a_i | b_i;
            FUNCT3_AND:  alu_res = a_i & b_i;
            default:     alu_res = '0;
        endcase
    end

    assign ex_res = !muldiv_i ? alu_res : (is_div ? corner_res : mul_res);

    assign quo_fix = neg_quo_q ? -div_quo : div_quo;
    assign rem_fix = neg_rem_q ? -div_rem : div_rem;
    assign div_res = rem_sel_q ? rem_fix : quo_fix;

    riscv_divider #(.XLEN(XLEN)) u_div (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (div_start),
        .abort_i     (flush_i),
        .dividend_i  (a_abs),
        .divisor_i   (b_abs),
        .quotient_o  (div_quo),
        .remainder_o (div_rem),
        .done_o      (div_done)
    );

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q && !out_ready_i;
        result_d    = result_q;
        rd_d        = rd_q;
        rd_lat_d    = rd_lat_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        rem_sel_d   = rem_sel_q;
        div_start   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_div && !b_zero && !div_ovf) begin
                        state_d   = ST_DIV;
                        div_start = 1'b1;
                        rd_lat_d  = rdi_i;
                        neg_quo_d = sa ^ sb;
                        neg_rem_d = sa;
                        rem_sel_d = funct3_i[1];
                    end else begin
                        result_d    = ex_res;
                        rd_d        = rdi_i;
                        out_valid_d = 1'b1;
                    end
                end
            end
            ST_DIV: begin
                if (div_done) state_d = ST_DONE;
            end
            ST_DONE: begin
                result_d    = div_res;
                rd_d        = rd_lat_q;
                out_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush_i) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            result_d    = result_q;
            rd_d        = rd_q;
            div_start   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            rd_q        <= '0;
            rd_lat_q    <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            rem_sel_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            rd_q        <= rd_d;
            rd_lat_q    <= rd_lat_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            rem_sel_q   <= rem_sel_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign result_o    = result_q;
    assign rd_o        = rd_q;

endmodule

// File: tb/tb_riscv_ex_mc.sv
// Scoreboard bench for riscv_ex_mc (XLEN=32): directed ops push expected
// results; a negedge monitor pops and compares on every output transfer.
module tb_riscv_ex_mc;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, alt, muldiv, out_valid, out_ready;
    logic [4:0]  rdi, rd;
    logic [31:0] a, b, result;
    logic [2:0]  funct3;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
    } exp_t;
    exp_t sb_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int last_wait;

    riscv_ex_mc #(.XLEN(32), .REGN(32)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .rdi_i(rdi),
        .a_i(a), .b_i(b), .funct3_i(funct3), .alt_i(alt), .muldiv_i(muldiv),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .result_o(result), .rd_o(rd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("spurious_output", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("result", result, e.res);
                chk("rd", rd, e.rd);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic issue(input logic [4:0] r, input logic [31:0] av, input logic [31:0] bv,
                         input logic [2:0] f3, input logic al, input logic md,
                         input logic push, input logic [31:0] exp);
        int n = 0;
        in_valid = 1'b1; rdi = r; a = av; b = bv; funct3 = f3; alt = al; muldiv = md;
        forever begin
            #1;
            if (in_ready || n >= 200) break;
            @(posedge clk);
            n++;
        end
        last_wait = n;
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
        end else begin
            if (push) sb_q.push_back('{res: exp, rd: r});
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        rdi = '0; a = '0; b = '0; funct3 = '0; alt = 1'b0; muldiv = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_rd", rd, 0);
        chk("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // ALU
        issue(5'd3, 32'd5, 32'hFFFF_FFF9, 3'b000, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
        chk("add_latency1", out_valid, 1);
        issue(5'd4, 32'd5, 32'd7, 3'b000, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);
        issue(5'd5, 32'h8000_0000, 32'd4, 3'b101, 1'b1, 1'b0, 1'b1, 32'hF800_0000);
        issue(5'd6, 32'h8000_0000, 32'd4, 3'b101, 1'b0, 1'b0, 1'b1, 32'h0800_0000);
        issue(5'd7, 32'd1, 32'hFFFF_FFFF, 3'b011, 1'b0, 1'b0, 1'b1, 32'd1);
        issue(5'd8, 32'd1, 32'hFFFF_FFFF, 3'b010, 1'b0, 1'b0, 1'b1, 32'd0);
        issue(5'd9, 32'hFFFF_FFFF, 32'd1, 3'b010, 1'b0, 1'b0, 1'b1, 32'd1);
        issue(5'd10, 32'd1, 32'h0000_003F, 3'b001, 1'b0, 1'b0, 1'b1, 32'h8000_0000);
        issue(5'd11, 32'hFF00_FF00, 32'h0F0F_0F0F, 3'b100, 1'b1, 1'b0, 1'b1, 32'hF00F_F00F);
        issue(5'd12, 32'h1234_0000, 32'h0000_5678, 3'b110, 1'b0, 1'b0, 1'b1, 32'h1234_5678);
        issue(5'd13, 32'hFFFF_0000, 32'h1234_5678, 3'b111, 1'b1, 1'b0, 1'b1, 32'h1234_0000);
        // MUL family
        issue(5'd14, 32'd3, 32'hFFFF_FFFE, 3'b000, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFA);
        issue(5'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b001, 1'b0, 1'b1, 1'b1, 32'h0000_0000);
        issue(5'd16, 32'h8000_0000, 32'h8000_0000, 3'b001, 1'b0, 1'b1, 1'b1, 32'h4000_0000);
        issue(5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b010, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
        issue(5'd18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b011, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE);
        @(posedge clk); #1;

        // DIV -7/2 with in_ready-low length and latency
        issue(5'd19, 32'hFFFF_FFF9, 32'd2, 3'b100, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFD);
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready || n >= 100) break;
            n++;
        end
        chk("div_in_ready_low_cycles", n, 33);
        chk("div_out_valid_at_xlen_plus_2", out_valid, 1);
        @(posedge clk); #1;
        issue(5'd20, 32'hFFFF_FFF9, 32'd2, 3'b110, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
        issue(5'd21, 32'd7, 32'hFFFF_FFFE, 3'b100, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFD);
        issue(5'd22, 32'd7, 32'hFFFF_FFFE, 3'b110, 1'b0, 1'b1, 1'b1, 32'd1);
        issue(5'd23, 32'd100, 32'd7, 3'b101, 1'b0, 1'b1, 1'b1, 32'd14);
        issue(5'd24, 32'd100, 32'd7, 3'b111, 1'b0, 1'b1, 1'b1, 32'd2);
        issue(5'd25, 32'hFFFF_FFFF, 32'h10, 3'b101, 1'b0, 1'b1, 1'b1, 32'h0FFF_FFFF);
        issue(5'd26, 32'hFFFF_FFFF, 32'h10, 3'b111, 1'b0, 1'b1, 1'b1, 32'h0000_000F);

        // Corner cases resolve with latency 1
        issue(5'd27, 32'd123, 32'd0, 3'b101, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
        chk("divu_by0_latency1", out_valid, 1);
        issue(5'd28, 32'd9, 32'd0, 3'b110, 1'b0, 1'b1, 1'b1, 32'd9);
        chk("rem_by0_latency1", out_valid, 1);
        issue(5'd29, 32'h8000_0000, 32'hFFFF_FFFF, 3'b100, 1'b0, 1'b1, 1'b1, 32'h8000_0000);
        chk("div_ovf_latency1", out_valid, 1);
        issue(5'd30, 32'h8000_0000, 32'hFFFF_FFFF, 3'b110, 1'b0, 1'b1, 1'b1, 32'd0);
        chk("rem_ovf_latency1", out_valid, 1);
        @(posedge clk); #1;

        // Backpressure
        out_ready = 1'b0;
        issue(5'd7, 32'd10, 32'd20, 3'b000, 1'b0, 1'b0, 1'b1, 32'd30);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_result_stable", result, 32'd30);
            chk("bp_rd_stable", rd, 5'd7);
            chk("bp_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        issue(5'd8, 32'h0000_F0F0, 32'h0000_0FF0, 3'b100, 1'b0, 1'b0, 1'b1, 32'h0000_FF00);
        chk("bp_accept_same_cycle", last_wait, 0);
        chk("bp_next_result", result, 32'h0000_FF00);
        @(posedge clk); #1;

        // Flush in divide cycle 10
        issue(5'd9, 32'd1000, 32'd3, 3'b100, 1'b0, 1'b1, 1'b0, 32'd0);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        #1;
        chk("flush_cycle_in_ready", in_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        #1;
        chk("post_flush_in_ready", in_ready, 1);
        issue(5'd10, 32'd1, 32'd1, 3'b000, 1'b0, 1'b0, 1'b1, 32'd2);
        chk("post_flush_accept_wait", last_wait, 0);
        repeat (40) @(posedge clk);
        #1;

        // Async reset mid-divide
        issue(5'd11, 32'd50, 32'd5, 3'b101, 1'b0, 1'b1, 1'b0, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_result", result, 0);
        chk("rst_mid_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        issue(5'd12, 32'd4, 32'd4, 3'b000, 1'b0, 1'b0, 1'b1, 32'd8);
        repeat (40) @(posedge clk);
        #1;

        chk("scoreboard_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/riscv_ex_mc.md
Name: riscv_ex_mc

Overview:
Parametrised execute stage. Supports the RV32I/RV64I integer ALU ops plus the M extension: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
- Single-cycle ALU/MUL path.
- Iterative, variable-latency divider.
- Valid/ready handshakes on both sides, so decode stalls while a divide is in flight.
- Flush input kills in-flight work on branch mispredict.
- Sits between decode/regfile read and memory stage.

Parameters:
XLEN, 32, datapath width (32 or 64)
REGN, 32, architectural register count
REGA, $clog2(REGN), register address width
SHW, $clog2(XLEN), shift amount width (low SHW bits of b)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
flush  in  1  synchronous kill of accepted/in-flight op
in_valid  in  1  operands valid
in_ready  out  1  stage can accept
rdi  in  REGA  destination register of incoming op
a  in  XLEN  operand 1
b  in  XLEN  operand 2 (rs2 or immediate; shamt = b[SHW-1:0])
funct3  in  3  RISC-V funct3
alt  in  1  funct7[5]: SUB / SRA select
muldiv  in  1  funct7[0]: M-extension op
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
result  out  XLEN  result
rd  out  REGA  destination register, paired with result

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; out_valid=0; result=0; rd=0.
  - Divider registers cleared.
  - in_ready=0 while rst is high.
- Accept: in_valid && in_ready at a clk edge.
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush. Combinational from state and out_ready.
- Output hold:
  - While out_valid && !out_ready, result and rd are stable.
  - out_valid drops only on out_ready or flush.
- State machine IDLE / DIV / DONE:
  - IDLE, accept, non-div op: result/rd registered, out_valid=1 next cycle. Latency 1. Back-to-back throughput 1/cycle.
  - IDLE, accept, muldiv && funct3[2]: latch operands/signs/rdi, go to DIV.
  - DIV: one restoring quotient bit per cycle. Counter runs XLEN-1 down to 0. At 0 go to DONE.
  - DONE: apply sign fixup, register result, out_valid=1, go to IDLE. Divide latency = XLEN+2 cycles from accept to out_valid.
- ALU, non-muldiv:
  - ADD/SUB by alt; SLL, SLT, SLTU, XOR; SRL/SRA by alt; OR, AND.
  - alt is ignored for all other funct3 values.
  - SLT/SLTU yield a zero-extended 0/1.
- MUL family: computed as a 2*XLEN-bit product.
  - MUL returns the low half.
  - MULH (s×s), MULHSU (s×u) and MULHU (u×u) return the high half.
- Divide corner cases (RISC-V mandated), resolved in the accept cycle without iterating (latency 1):
  - b==0: DIV/DIVU → all-ones; REM/REMU → a.
  - Signed overflow (a==MIN, b==-1): DIV → MIN; REM → 0.
- Flush:
  - Returns state to IDLE and clears out_valid at the next edge.
  - A new op is not accepted in the flush cycle.
  - Flush has priority over accept and over the DONE write.
- Simultaneous output drain and accept in IDLE is allowed (pipeline flow).
- Reset mid-divide abandons the op; no output is produced.

Decomposition:
- Shared package, extending the existing ISA include:
  - FUNCT3_* constants plus FUNCT3_MUL / MULH / MULHSU / MULHU / DIV / DIVU / REM / REMU.
  - State encoding localparams.
- Sub-module riscv_divider(XLEN): iterative unsigned restoring core.
  - Inputs: start, dividend, divisor.
  - Outputs: quotient, remainder, done.
  - Sign handling stays in riscv_ex_mc.
- ALU and multiplier stay inline.

Test Plan:
- After reset, ADD a=5, b=-7 → out_valid next cycle, result=0xFFFFFFFE, rd=rdi. SUB (alt=1) 5-7 gives the same.
- SRA a=0x80000000, shamt=4 → 0xF8000000. SRL of the same → 0x08000000. SLTU a=1, b=0xFFFFFFFF → 1.
- DIV a=-7, b=2:
  - in_ready low for XLEN+1 cycles.
  - result=-3; REM same operands → -1.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- Corner cases:
  - DIVU x/0 → 0xFFFFFFFF; REM 9/0 → 9.
  - DIV 0x80000000/-1 → 0x80000000; REM of the same → 0. Each with latency 1.
- Backpressure:
  - Hold out_ready=0 for 3 cycles: result stable, in_ready=0.
  - Release: next op accepted the same cycle the result drains.
- Flush and reset mid-op:
  - Flush at divide cycle 10 → no out_valid; next ADD accepted one cycle later.
  - Async rst mid-divide → out_valid=0, result=0 immediately.
